keyboard_op_decoder: RTL and testbench
======================================

# keyboard_op_decoder

Producer side of the keyboard-operation handshake consumed by the game logic. Receives PS/2 frames from the keyboard, validates them, tracks make/break/extended prefixes, and maps key presses to 3-bit operation codes (W/A/S/D/SPACE/Z). Each operation is presented on `keyboard_data` with `keyboard_ready` and held until the game logic acknowledges it with `keyboard_read_fin`.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 10000: idle `clock` cycles mid-frame before the receiver aborts the frame (200 µs at 50 MHz).
- `SYNC_STAGES`, 2: flip-flop stages on `ps2_clock` and `ps2_data` (≥2).

Ports:
- `clock`  in  1: system clock; the single clock domain.
- `reset`  in  1: synchronous, active-high.
- `ps2_clock`  in  1: raw PS/2 clock, asynchronous.
- `ps2_data`  in  1: raw PS/2 data, asynchronous.
- `keyboard_read_fin`  in  1: consumer acknowledge; 1 means data has been read.
- `keyboard_ready`  out  1: operation valid.
- `keyboard_data`  out  3: operation code. 000 W, 001 A, 010 S, 011 D, 100 SPACE, 101 Z.
- `frame_error_o_test`  out  1: one-cycle pulse on a rejected frame (parity, start, stop or timeout).

## Operation
- Synchronize both PS/2 lines through `SYNC_STAGES` flops. A falling edge is the synchronized clock going 1→0 between consecutive cycles.
- Receiver FSM has three states:
  - IDLE: on a falling edge with data=0 (start bit), go to RECV with bit_cnt=1. Otherwise stay in IDLE.
  - RECV: on each falling edge, shift data in LSB first. Bits 1–8 are data, bit 9 is parity, bit 10 is stop. On the edge that captures bit 10, go to CHECK.
  - CHECK: one cycle. The frame is valid if parity is odd over data+parity and stop=1. Valid → pass the byte to the code stage. Invalid → pulse `frame_error_o_test`. Either way return to IDLE.
- Watchdog in RECV: count cycles since the last falling edge. When the count reaches `TIMEOUT_CYCLES`, return to IDLE and pulse `frame_error_o_test`.
- Code stage, processing one valid byte:
  - 0xE0: set `ext`.
  - 0xF0: set `brk`.
  - Any other byte with `brk`=1: clear `brk` and `ext`; no output.
  - Otherwise, map the byte:
    - With `ext`=1: 0x75→W, 0x6B→A, 0x72→S, 0x74→D.
    - With `ext`=0: 0x1D→W, 0x1C→A, 0x1B→S, 0x23→D, 0x29→SPACE, 0x1A→Z.
    - Clear `ext` after mapping.
    - Unmapped codes are dropped silently.
- Output slot holds one entry:
  - A mapped key loads `keyboard_data` and sets `keyboard_ready` on the next cycle.
  - If `keyboard_ready` is already 1, the new code overwrites `keyboard_data` and `keyboard_ready` stays 1. Latest key wins.
- Handshake:
  - While `keyboard_ready`=1 and `keyboard_read_fin`=1 in the same cycle, clear `keyboard_ready` next cycle.
  - If a new mapped key is loaded in that same cycle, the load wins: `keyboard_ready` stays 1 with the new data.
  - `keyboard_read_fin` while `keyboard_ready`=0 is ignored.
- `keyboard_data` holds its last value while `keyboard_ready`=0.

## Timing
- Reset values: `keyboard_ready`=0, `keyboard_data`=3'b110 (NONE), `frame_error_o_test`=0. FSM in IDLE; `ext`, `brk`, watchdog and shift register cleared.
- Reset mid-frame discards the partial frame. Reset with `keyboard_ready`=1 drops the pending operation.
- Latency, with the 10th-bit falling edge detected in cycle N:
  - CHECK in N+1.
  - Code stage in N+2.
  - `keyboard_ready`=1 in N+3.
  - Total from the raw pin edge is N+3+`SYNC_STAGES`.
- Acknowledge: `keyboard_ready` falls 1 cycle after the first cycle in which `keyboard_ready`&`keyboard_read_fin`=1.
- Minimum spacing between outputs is one PS/2 frame (~11 × 60 µs). Back-to-back overwrite only happens under a slow consumer.

## Configuration
- `KEYBOARD_REPEAT_FILTER_EN` defined:
  - Store the last mapped make code (including `ext`) in `held_key`.
  - A repeated make of the same code before its break is dropped.
  - The matching break clears `held_key`.
  - Reset clears `held_key`.
- Not defined: every typematic repeat produces a new operation.

## Test plan
- Reset, then frame 0x1D with correct parity → `keyboard_ready`=1, `keyboard_data`=000. Hold `keyboard_read_fin`=1 → `keyboard_ready`=0 one cycle later.
- Sequence E0 6B → `keyboard_data`=001. Then E0 F0 6B → no new `keyboard_ready`.
- Frame 0x29 with even parity → `frame_error_o_test` pulse, `keyboard_ready` stays 0. Next valid 0x1A → `keyboard_data`=101.
- Start bit plus 4 bits, then idle for `TIMEOUT_CYCLES` → `frame_error_o_test` pulse. Following valid 0x1B → `keyboard_data`=010.
- 0x23, then 0x1C with no acknowledge → `keyboard_ready` stays 1 continuously and `keyboard_data` goes 011→001. Also drive `keyboard_read_fin` in the load cycle → `keyboard_ready` stays 1.
- With `KEYBOARD_REPEAT_FILTER_EN`: 0x1D 0x1D 0x1D F0 1D 0x1D → exactly two W operations. Without the macro → four.

Source files
------------

// File: rtl/keyboard_op_decoder.sv
// PS/2 keyboard receiver and operation decoder: validates frames, tracks E0/F0 prefixes, maps keys to 3-bit ops.
// Optional typematic repeat filter enabled by defining KEYBOARD_REPEAT_FILTER_EN.
module keyboard_op_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 10000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data,
    output logic       frame_error_o_test
);

    localparam int unsigned WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FRAME_W = 10;
    localparam logic [2:0]  OP_NONE = 3'b110;

    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_CHECK} state_e;

    state_e               state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                 clk_prev_q;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [7:0]           byte_q, byte_d;
    logic                 byte_vld_q, byte_vld_d;
    logic                 ext_q, ext_d, brk_q, brk_d;
    logic                 ready_q, ready_d;
    logic [2:0]           data_q, data_d;
    logic                 err_q, err_d;

    logic                 ps2_clk_s, ps2_dat_s, fall_c;
    logic [WD_W-1:0]      wd_inc_c;
    logic [3:0]           map_c;

    // Returns {hit, op} for a make code under the current extended-prefix state.
    function automatic logic [3:0] map_code(input logic ext, input logic [7:0] code);
        logic [3:0] r;
        r = 4'b0000;
        if (ext) begin
            case (code)
                8'h75:   r = 4'b1000;
                8'h6B:   r = 4'b1001;
                8'h72:   r = 4'b1010;
                8'h74:   r = 4'b1011;
                default: r = 4'b0000;
            endcase
        end else begin
            case (code)
                8'h1D:   r = 4'b1000;
                8'h1C:   r = 4'b1001;
                8'h1B:   r = 4'b1010;
                8'h23:   r = 4'b1011;
                8'h29:   r = 4'b1100;
                8'h1A:   r = 4'b1101;
                default: r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];
    assign fall_c    = clk_prev_q & ~ps2_clk_s;
    assign wd_inc_c  = wd_q + WD_W'(1);
    assign map_c     = map_code(ext_q, byte_q);

`ifdef KEYBOARD_REPEAT_FILTER_EN
    logic [8:0] held_q, held_d;
    logic       held_vld_q, held_vld_d;
    logic       held_match_c;
    assign held_match_c = held_vld_q && (held_q == {ext_q, byte_q});
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            wd_q       <= '0;
            byte_q     <= '0;
            byte_vld_q <= 1'b0;
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            ready_q    <= 1'b0;
            data_q     <= OP_NONE;
            err_q      <= 1'b0;
`ifdef KEYBOARD_REPEAT_FILTER_EN
            held_q     <= '0;
            held_vld_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clock};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
            clk_prev_q <= ps2_clk_s;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            wd_q       <= wd_d;
            byte_q     <= byte_d;
            byte_vld_q <= byte_vld_d;
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            err_q      <= err_d;
`ifdef KEYBOARD_REPEAT_FILTER_EN
            held_q     <= held_d;
            held_vld_q <= held_vld_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        wd_d       = '0;
        byte_d     = byte_q;
        byte_vld_d = 1'b0;
        err_d      = 1'b0;
        ext_d      = ext_q;
        brk_d      = brk_q;
        ready_d    = ready_q;
        data_d     = data_q;
`ifdef KEYBOARD_REPEAT_FILTER_EN
        held_d     = held_q;
        held_vld_d = held_vld_q;
`endif

        // Frame receiver; shift register ends as {stop, parity, data[7:0]}.
        case (state_q)
            ST_IDLE: begin
                if (fall_c && !ps2_dat_s) begin
                    state_d   = ST_RECV;
                    bit_cnt_d = CNT_W'(1);
                end
            end
            ST_RECV: begin
                if (fall_c) begin
                    shift_d = {ps2_dat_s, shift_q[FRAME_W-1:1]};
                    if (bit_cnt_q == CNT_W'(10)) state_d = ST_CHECK;
                    else                         bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end else if (wd_inc_c == WD_W'(TIMEOUT_CYCLES)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_inc_c;
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                if ((^shift_q[8:0]) && shift_q[9]) begin
                    byte_vld_d = 1'b1;
                    byte_d     = shift_q[7:0];
                end else begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (ready_q && keyboard_read_fin) ready_d = 1'b0;

        // Code stage: prefixes, break handling, then key mapping; a load beats an acknowledge.
        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (brk_q) begin
                brk_d = 1'b0;
                ext_d = 1'b0;
`ifdef KEYBOARD_REPEAT_FILTER_EN
                if (held_match_c) held_vld_d = 1'b0;
`endif
            end else begin
                ext_d = 1'b0;
`ifdef KEYBOARD_REPEAT_FILTER_EN
                if (map_c[3] && !held_match_c) begin
                    ready_d    = 1'b1;
                    data_d     = map_c[2:0];
                    held_d     = {ext_q, byte_q};
                    held_vld_d = 1'b1;
                end
`else
                if (map_c[3]) begin
                    ready_d = 1'b1;
                    data_d  = map_c[2:0];
                end
`endif
            end
        end
    end

    assign keyboard_ready     = ready_q;
    assign keyboard_data      = data_q;
    assign frame_error_o_test = err_q;

endmodule

// File: tb/tb_keyboard_op_decoder.sv
// Directed bench for keyboard_op_decoder: latency, prefixes, frame errors, overwrite and handshake.
module tb_keyboard_op_decoder;

    localparam int unsigned TMO  = 64;
    localparam int unsigned HALF = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       ps2_clock;
    logic       ps2_data;
    logic       keyboard_read_fin;
    logic       keyboard_ready;
    logic [2:0] keyboard_data;
    logic       frame_error_o_test;

    int n_cmp = 0;
    int n_bad = 0;
    int rises = 0, falls = 0, err_pulses = 0, err_cycles = 0;
    logic prev_rdy = 1'b0, prev_err = 1'b0;

    typedef struct {
        logic       pre_e0;
        logic [7:0] code;
        logic       exp_rdy;
        logic [2:0] exp_op;
    } vec_t;

    vec_t vecs[12];

    always #5 clock = ~clock;

    keyboard_op_decoder #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(2)) dut (
        .clock             (clock),
        .reset             (reset),
        .ps2_clock         (ps2_clock),
        .ps2_data          (ps2_data),
        .keyboard_read_fin (keyboard_read_fin),
        .keyboard_ready    (keyboard_ready),
        .keyboard_data     (keyboard_data),
        .frame_error_o_test(frame_error_o_test)
    );

    // Edge/pulse monitor on the inactive clock edge.
    always @(negedge clock) begin
        if (keyboard_ready === 1'b1 && !prev_rdy) rises++;
        if (keyboard_ready === 1'b0 && prev_rdy) falls++;
        if (frame_error_o_test === 1'b1) err_cycles++;
        if (frame_error_o_test === 1'b1 && !prev_err) err_pulses++;
        prev_rdy = (keyboard_ready === 1'b1);
        prev_err = (frame_error_o_test === 1'b1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (HALF) tick();
        ps2_clock = 1'b0;
        repeat (HALF) tick();
        ps2_clock = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        send_bits(b, bad_par, 11);
        repeat (8) tick();
    endtask

    task automatic ack();
        keyboard_read_fin = 1'b1;
        tick();
        tick();
        keyboard_read_fin = 1'b0;
        check("ack_clears", 32'(keyboard_ready), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int r0, e0, f0, exp_ops;
        vecs[0]  = '{1'b0, 8'h1D, 1'b1, 3'd0};
        vecs[1]  = '{1'b1, 8'h1D, 1'b0, 3'd0};
        vecs[2]  = '{1'b0, 8'h1C, 1'b1, 3'd1};
        vecs[3]  = '{1'b0, 8'h1B, 1'b1, 3'd2};
        vecs[4]  = '{1'b0, 8'h23, 1'b1, 3'd3};
        vecs[5]  = '{1'b0, 8'h29, 1'b1, 3'd4};
        vecs[6]  = '{1'b0, 8'h1A, 1'b1, 3'd5};
        vecs[7]  = '{1'b1, 8'h75, 1'b1, 3'd0};
        vecs[8]  = '{1'b1, 8'h6B, 1'b1, 3'd1};
        vecs[9]  = '{1'b1, 8'h72, 1'b1, 3'd2};
        vecs[10] = '{1'b1, 8'h74, 1'b1, 3'd3};
        vecs[11] = '{1'b0, 8'h15, 1'b0, 3'd0};

        ps2_clock = 1'b1;
        ps2_data = 1'b1;
        keyboard_read_fin = 1'b0;
        do_reset();
        check("rst_ready", 32'(keyboard_ready), 32'd0);
        check("rst_data", 32'(keyboard_data), 32'd6);
        check("rst_err", 32'(frame_error_o_test), 32'd0);

        // 0x1D with exact latency from the stop-bit falling edge, then acknowledge.
        send_bits(8'h1D, 1'b0, 10);
        ps2_data = 1'b1;
        repeat (HALF) tick();
        ps2_clock = 1'b0;
        repeat (4) tick();
        check("lat_not_yet", 32'(keyboard_ready), 32'd0);
        tick();
        check("lat_ready", 32'(keyboard_ready), 32'd1);
        check("lat_data_w", 32'(keyboard_data), 32'd0);
        keyboard_read_fin = 1'b1;
        tick();
        check("ack_one_cycle", 32'(keyboard_ready), 32'd0);
        keyboard_read_fin = 1'b0;
        repeat (HALF) tick();
        ps2_clock = 1'b1;
        repeat (8) tick();
        keyboard_read_fin = 1'b1;
        repeat (3) tick();
        check("fin_idle_ignored", 32'(keyboard_ready), 32'd0);
        keyboard_read_fin = 1'b0;

        // Extended make, then extended break must not produce an op.
        send_frame(8'hE0, 1'b0);
        send_frame(8'h6B, 1'b0);
        check("ext_a_rdy", 32'(keyboard_ready), 32'd1);
        check("ext_a_data", 32'(keyboard_data), 32'd1);
        ack();
        r0 = rises;
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h6B, 1'b0);
        check("ext_break_no_op", 32'(rises - r0), 32'd0);
        check("ext_break_hold", 32'(keyboard_data), 32'd1);

        // Bad parity frame is rejected, next good frame decodes.
        e0 = err_pulses;
        send_frame(8'h29, 1'b1);
        check("parity_err", 32'(err_pulses - e0), 32'd1);
        check("parity_no_rdy", 32'(keyboard_ready), 32'd0);
        send_frame(8'h1A, 1'b0);
        check("z_rdy", 32'(keyboard_ready), 32'd1);
        check("z_data", 32'(keyboard_data), 32'd5);
        ack();

        // Truncated frame hits the watchdog.
        e0 = err_pulses;
        send_bits(8'h55, 1'b0, 5);
        repeat (TMO + 10) tick();
        check("timeout_err", 32'(err_pulses - e0), 32'd1);
        check("err_one_cycle", 32'(err_cycles), 32'(err_pulses));
        send_frame(8'h1B, 1'b0);
        check("s_rdy", 32'(keyboard_ready), 32'd1);
        check("s_data", 32'(keyboard_data), 32'd2);
        ack();

        // Slow consumer: overwrite keeps ready high; acknowledge in load cycle loses to load.
        f0 = falls;
        send_frame(8'h23, 1'b0);
        check("d_data", 32'(keyboard_data), 32'd3);
        send_frame(8'h1C, 1'b0);
        check("ovr_rdy", 32'(keyboard_ready), 32'd1);
        check("ovr_data", 32'(keyboard_data), 32'd1);
        check("ovr_no_drop", 32'(falls - f0), 32'd0);
        send_bits(8'h1D, 1'b0, 10);
        ps2_data = 1'b1;
        repeat (HALF) tick();
        ps2_clock = 1'b0;
        repeat (4) tick();
        keyboard_read_fin = 1'b1;
        tick();
        keyboard_read_fin = 1'b0;
        check("load_wins_rdy", 32'(keyboard_ready), 32'd1);
        check("load_wins_data", 32'(keyboard_data), 32'd0);
        repeat (HALF) tick();
        ps2_clock = 1'b1;
        repeat (4) tick();
        check("load_wins_no_drop", 32'(falls - f0), 32'd0);

        // Reset drops a pending op.
        do_reset();
        check("rst_drop_rdy", 32'(keyboard_ready), 32'd0);
        check("rst_drop_data", 32'(keyboard_data), 32'd6);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].pre_e0) send_frame(8'hE0, 1'b0);
            send_frame(vecs[i].code, 1'b0);
            check($sformatf("vec%0d_rdy", i), 32'(keyboard_ready), 32'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy) begin
                check($sformatf("vec%0d_data", i), 32'(keyboard_data), 32'(vecs[i].exp_op));
                ack();
            end
        end

        // Typematic repeats with a fast consumer.
        do_reset();
`ifdef KEYBOARD_REPEAT_FILTER_EN
        exp_ops = 2;
`else
        exp_ops = 4;
`endif
        keyboard_read_fin = 1'b1;
        r0 = rises;
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1D, 1'b0);
        send_frame(8'h1D, 1'b0);
        repeat (4) tick();
        keyboard_read_fin = 1'b0;
        check("repeat_ops", 32'(rises - r0), 32'(exp_ops));
        check("repeat_data", 32'(keyboard_data), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
